// File: rtl/raster_pkg.sv
// Shared types, screen defaults and small signed helpers for the triangle rasteriser front end.
package raster_pkg;

  localparam int COORD_W      = 11;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic        [COORD_W-1:0] coord_t;
  typedef logic signed [COORD_W-1:0] scoord_t;
  typedef logic signed [COORD_W:0]   wcoord_t;

  typedef struct packed {
    scoord_t x;
    scoord_t y;
  } vertex_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic wcoord_t sext(input coord_t v);
    return wcoord_t'({v[COORD_W-1], v});
  endfunction

  function automatic wcoord_t min3(input wcoord_t a, input wcoord_t b, input wcoord_t c);
    wcoord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic wcoord_t max3(input wcoord_t a, input wcoord_t b, input wcoord_t c);
    wcoord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/raster_bbox.sv
// Combinational screen-clamped bounding box of three signed vertices.
module raster_bbox
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic [COORD_W-1:0] i_v0_x,
  input  logic [COORD_W-1:0] i_v0_y,
  input  logic [COORD_W-1:0] i_v1_x,
  input  logic [COORD_W-1:0] i_v1_y,
  input  logic [COORD_W-1:0] i_v2_x,
  input  logic [COORD_W-1:0] i_v2_y,
  output logic [COORD_W-1:0] o_xmin,
  output logic [COORD_W-1:0] o_xmax,
  output logic [COORD_W-1:0] o_ymin,
  output logic [COORD_W-1:0] o_ymax,
  output logic               o_empty
);

  localparam wcoord_t XLIM = wcoord_t'(SCREEN_W - 1);
  localparam wcoord_t YLIM = wcoord_t'(SCREEN_H - 1);

  wcoord_t w_xlo, w_xhi, w_ylo, w_yhi;
  wcoord_t w_xmin, w_xmax, w_ymin, w_ymax;

  // One extra bit keeps min/max and the empty test exact for any signed input.
  always_comb begin
    w_xlo   = min3(sext(i_v0_x), sext(i_v1_x), sext(i_v2_x));
    w_xhi   = max3(sext(i_v0_x), sext(i_v1_x), sext(i_v2_x));
    w_ylo   = min3(sext(i_v0_y), sext(i_v1_y), sext(i_v2_y));
    w_yhi   = max3(sext(i_v0_y), sext(i_v1_y), sext(i_v2_y));
    w_xmin  = w_xlo[COORD_W] ? '0 : w_xlo;
    w_ymin  = w_ylo[COORD_W] ? '0 : w_ylo;
    w_xmax  = (w_xhi > XLIM) ? XLIM : w_xhi;
    w_ymax  = (w_yhi > YLIM) ? YLIM : w_yhi;
    o_empty = (w_xmin > w_xmax) || (w_ymin > w_ymax);
    o_xmin  = w_xmin[COORD_W-1:0];
    o_xmax  = w_xmax[COORD_W-1:0];
    o_ymin  = w_ymin[COORD_W-1:0];
    o_ymax  = w_ymax[COORD_W-1:0];
  end

endmodule

// File: rtl/tri_raster_ctrl.sv
// Triangle scan sequencer: bounding-box walk into three lockstep edge units, covered-pixel fragment out.
//   state | meaning
//   IDLE  | waiting for a triangle, tri_ready high
//   SETUP | vertices held, box and cursor loaded
//   SCAN  | issuing box pixels row-major
//   DRAIN | waiting for edge results and last fragment
//   DONE  | one-cycle done pulse
module tri_raster_ctrl
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int INFL_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tri_valid,
  output logic               o_tri_ready,
  input  logic [COORD_W-1:0] i_v0_x,
  input  logic [COORD_W-1:0] i_v0_y,
  input  logic [COORD_W-1:0] i_v1_x,
  input  logic [COORD_W-1:0] i_v1_y,
  input  logic [COORD_W-1:0] i_v2_x,
  input  logic [COORD_W-1:0] i_v2_y,
  output logic               o_eu_in_valid,
  input  logic               i_eu_in_ready,
  output logic [COORD_W-1:0] o_eu_px_x,
  output logic [COORD_W-1:0] o_eu_px_y,
  output logic [COORD_W-1:0] o_eu_va0_x,
  output logic [COORD_W-1:0] o_eu_va0_y,
  output logic [COORD_W-1:0] o_eu_vb0_x,
  output logic [COORD_W-1:0] o_eu_vb0_y,
  output logic [COORD_W-1:0] o_eu_va1_x,
  output logic [COORD_W-1:0] o_eu_va1_y,
  output logic [COORD_W-1:0] o_eu_vb1_x,
  output logic [COORD_W-1:0] o_eu_vb1_y,
  output logic [COORD_W-1:0] o_eu_va2_x,
  output logic [COORD_W-1:0] o_eu_va2_y,
  output logic [COORD_W-1:0] o_eu_vb2_x,
  output logic [COORD_W-1:0] o_eu_vb2_y,
  input  logic [2:0]         i_eu_out_valid,
  input  logic [2:0]         i_eu_inside,
  input  logic [COORD_W-1:0] i_eu_res_x,
  input  logic [COORD_W-1:0] i_eu_res_y,
  output logic               o_eu_out_ready,
  output logic               o_frag_valid,
  input  logic               i_frag_ready,
  output logic [COORD_W-1:0] o_frag_x,
  output logic [COORD_W-1:0] o_frag_y,
  output logic               o_busy,
  output logic               o_done
);

  state_t              r_state;
  vertex_t             r_v0, r_v1, r_v2;
  coord_t              r_xmin, r_xmax, r_ymax;
  coord_t              r_x, r_y;
  logic                r_tri_ready, r_busy, r_done, r_in_valid;
  logic                r_frag_valid;
  coord_t              r_frag_x, r_frag_y;
  logic [INFL_W-1:0]   r_inflight;

  coord_t              w_xmin, w_xmax, w_ymin, w_ymax;
  logic                w_empty;
  logic                w_issue, w_out_ready, w_retire, w_hit;

  raster_bbox #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_bbox (
    .i_v0_x  (r_v0.x),
    .i_v0_y  (r_v0.y),
    .i_v1_x  (r_v1.x),
    .i_v1_y  (r_v1.y),
    .i_v2_x  (r_v2.x),
    .i_v2_y  (r_v2.y),
    .o_xmin  (w_xmin),
    .o_xmax  (w_xmax),
    .o_ymin  (w_ymin),
    .o_ymax  (w_ymax),
    .o_empty (w_empty)
  );

  assign w_issue     = r_in_valid & i_eu_in_ready;
  assign w_out_ready = ~r_frag_valid | i_frag_ready;
  // A result is only taken when all three lockstep units present it together.
  assign w_retire    = (&i_eu_out_valid) & w_out_ready;
  assign w_hit       = w_retire & (&i_eu_inside);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_v0        <= '0;
      r_v1        <= '0;
      r_v2        <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymax      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_tri_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_tri_valid) begin
            r_v0        <= {i_v0_x, i_v0_y};
            r_v1        <= {i_v1_x, i_v1_y};
            r_v2        <= {i_v2_x, i_v2_y};
            r_tri_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_xmin <= w_xmin;
          r_xmax <= w_xmax;
          r_ymax <= w_ymax;
          r_x    <= w_xmin;
          r_y    <= w_ymin;
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_in_valid <= 1'b1;
            r_state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_issue) begin
            if (r_x == r_xmax) begin
              r_x <= r_xmin;
              if (r_y == r_ymax) begin
                r_in_valid <= 1'b0;
                r_state    <= ST_DRAIN;
              end else begin
                r_y <= r_y + coord_t'(1);
              end
            end else begin
              r_x <= r_x + coord_t'(1);
            end
          end
        end
        ST_DRAIN: begin
          if ((r_inflight == '0) && !r_frag_valid) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_tri_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frag_valid <= 1'b0;
      r_frag_x     <= '0;
      r_frag_y     <= '0;
      r_inflight   <= '0;
    end else begin
      if (w_hit) begin
        r_frag_valid <= 1'b1;
        r_frag_x     <= i_eu_res_x;
        r_frag_y     <= i_eu_res_y;
      end else if (i_frag_ready) begin
        r_frag_valid <= 1'b0;
      end
      case ({w_issue, w_retire})
        2'b10:   r_inflight <= r_inflight + INFL_W'(1);
        2'b01:   r_inflight <= r_inflight - INFL_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign o_tri_ready    = r_tri_ready;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_eu_in_valid  = r_in_valid;
  assign o_eu_px_x      = r_x;
  assign o_eu_px_y      = r_y;
  assign o_eu_out_ready = w_out_ready;
  assign o_frag_valid   = r_frag_valid;
  assign o_frag_x       = r_frag_x;
  assign o_frag_y       = r_frag_y;

  // Unit k evaluates edge Vk -> V(k+1)%3.
  assign o_eu_va0_x = r_v0.x;
  assign o_eu_va0_y = r_v0.y;
  assign o_eu_vb0_x = r_v1.x;
  assign o_eu_vb0_y = r_v1.y;
  assign o_eu_va1_x = r_v1.x;
  assign o_eu_va1_y = r_v1.y;
  assign o_eu_vb1_x = r_v2.x;
  assign o_eu_vb1_y = r_v2.y;
  assign o_eu_va2_x = r_v2.x;
  assign o_eu_va2_y = r_v2.y;
  assign o_eu_vb2_x = r_v0.x;
  assign o_eu_vb2_y = r_v0.y;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Bench for tri_raster_ctrl: edge-unit pipeline stand-in plus a box/coverage reference model.
module tb_tri_raster_ctrl;

  localparam int CW  = 11;
  localparam int SW  = 640;
  localparam int SH  = 480;

  typedef logic [2*CW-1:0] pix_t;
  typedef pix_t pix_q_t[$];
  typedef struct {
    int       x;
    int       y;
    logic [2:0] ins;
    bit       shown;
  } pend_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          tri_valid, tri_ready;
  logic [CW-1:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
  logic          eu_in_valid, eu_in_ready;
  logic [CW-1:0] px_x, px_y;
  logic [CW-1:0] va0_x, va0_y, vb0_x, vb0_y;
  logic [CW-1:0] va1_x, va1_y, vb1_x, vb1_y;
  logic [CW-1:0] va2_x, va2_y, vb2_x, vb2_y;
  logic [2:0]    eu_out_valid, eu_inside;
  logic [CW-1:0] res_x, res_y;
  logic          eu_out_ready;
  logic          frag_valid, frag_ready;
  logic [CW-1:0] frag_x, frag_y;
  logic          busy, done;

  tri_raster_ctrl dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_tri_valid    (tri_valid),
    .o_tri_ready    (tri_ready),
    .i_v0_x         (v0_x),
    .i_v0_y         (v0_y),
    .i_v1_x         (v1_x),
    .i_v1_y         (v1_y),
    .i_v2_x         (v2_x),
    .i_v2_y         (v2_y),
    .o_eu_in_valid  (eu_in_valid),
    .i_eu_in_ready  (eu_in_ready),
    .o_eu_px_x      (px_x),
    .o_eu_px_y      (px_y),
    .o_eu_va0_x     (va0_x),
    .o_eu_va0_y     (va0_y),
    .o_eu_vb0_x     (vb0_x),
    .o_eu_vb0_y     (vb0_y),
    .o_eu_va1_x     (va1_x),
    .o_eu_va1_y     (va1_y),
    .o_eu_vb1_x     (vb1_x),
    .o_eu_vb1_y     (vb1_y),
    .o_eu_va2_x     (va2_x),
    .o_eu_va2_y     (va2_y),
    .o_eu_vb2_x     (vb2_x),
    .o_eu_vb2_y     (vb2_y),
    .i_eu_out_valid (eu_out_valid),
    .i_eu_inside    (eu_inside),
    .i_eu_res_x     (res_x),
    .i_eu_res_y     (res_y),
    .o_eu_out_ready (eu_out_ready),
    .o_frag_valid   (frag_valid),
    .i_frag_ready   (frag_ready),
    .o_frag_x       (frag_x),
    .o_frag_y       (frag_y),
    .o_busy         (busy),
    .o_done         (done)
  );

  pend_t  pq[$];
  pix_q_t act_issue, act_frag, exp_issue, exp_frag;
  int     cyc = 0;
  int     hs_cyc, first_iss_cyc, last_iss_cyc, done_cyc;
  int     done_cnt = 0;
  int     mode = 0;
  int     n_checks = 0;
  int     n_pass = 0;

  function automatic int sv(input logic [CW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic bit edge_in(input int ax, input int ay, input int bx, input int by,
                                 input int px, input int py);
    return ((bx - ax) * (py - ay) - (by - ay) * (px - ax)) >= 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit same_q(input pix_q_t a, input pix_q_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Edge units: queue of in-flight pixels, head shown to the DUT, occasionally with staggered valids.
  always begin : eu_env
    pend_t e;
    @(negedge clk);
    cyc++;
    if (pq.size() > 0) begin
      res_x     = CW'(pq[0].x);
      res_y     = CW'(pq[0].y);
      eu_inside = pq[0].ins;
      if (mode == 1 && !pq[0].shown && $urandom_range(0, 1) == 1)
        eu_out_valid = 3'($urandom_range(1, 6));
      else
        eu_out_valid = 3'b111;
      pq[0].shown = 1'b1;
    end else begin
      res_x        = '0;
      res_y        = '0;
      eu_inside    = 3'b000;
      eu_out_valid = 3'b000;
    end
    if (mode == 1) begin
      eu_in_ready = (pq.size() < 4) && ($urandom_range(0, 3) != 0);
      frag_ready  = (cyc % 3 == 0);
    end else begin
      eu_in_ready = (pq.size() < 4);
      frag_ready  = 1'b1;
    end
    #1;
    if (reset) begin
      pq.delete();
    end else begin
      if ((&eu_out_valid) && eu_out_ready) pq.delete(0);
      if (eu_in_valid && eu_in_ready) begin
        e.x      = int'(px_x);
        e.y      = int'(px_y);
        e.ins[0] = edge_in(sv(va0_x), sv(va0_y), sv(vb0_x), sv(vb0_y), e.x, e.y);
        e.ins[1] = edge_in(sv(va1_x), sv(va1_y), sv(vb1_x), sv(vb1_y), e.x, e.y);
        e.ins[2] = edge_in(sv(va2_x), sv(va2_y), sv(vb2_x), sv(vb2_y), e.x, e.y);
        e.shown  = 1'b0;
        pq.push_back(e);
        act_issue.push_back({px_x, px_y});
        if (act_issue.size() == 1) first_iss_cyc = cyc;
        last_iss_cyc = cyc;
      end
      if (frag_valid && frag_ready) act_frag.push_back({frag_x, frag_y});
      if (tri_valid && tri_ready) hs_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic build_exp(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
    int xmn, xmx, ymn, ymx;
    xmn = imax(0, imin(x0, imin(x1, x2)));
    xmx = imin(SW - 1, imax(x0, imax(x1, x2)));
    ymn = imax(0, imin(y0, imin(y1, y2)));
    ymx = imin(SH - 1, imax(y0, imax(y1, y2)));
    exp_issue.delete();
    exp_frag.delete();
    for (int y = ymn; y <= ymx; y++) begin
      for (int x = xmn; x <= xmx; x++) begin
        exp_issue.push_back({CW'(x), CW'(y)});
        if (edge_in(x0, y0, x1, y1, x, y) && edge_in(x1, y1, x2, y2, x, y) &&
            edge_in(x2, y2, x0, y0, x, y))
          exp_frag.push_back({CW'(x), CW'(y)});
      end
    end
  endtask

  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2);
    act_issue.delete();
    act_frag.delete();
    @(negedge clk);
    tri_valid = 1'b1;
    v0_x = CW'(x0); v0_y = CW'(y0);
    v1_x = CW'(x1); v1_y = CW'(y1);
    v2_x = CW'(x2); v2_y = CW'(y2);
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  task automatic run_tri(input string tag, input int x0, input int y0, input int x1,
                         input int y1, input int x2, input int y2);
    int  d0;
    bit  got;
    build_exp(x0, y0, x1, y1, x2, y2);
    d0 = done_cnt;
    send_tri(x0, y0, x1, y1, x2, y2);
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      #2;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    @(negedge clk);
    #2;
    chk({tag, "_tri_ready_after_done"}, 64'(tri_ready), 64'd1);
    chk({tag, "_busy_after_done"}, 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_issue_cnt"}, 64'(act_issue.size()), 64'(exp_issue.size()));
    chk({tag, "_issue_seq"}, 64'(same_q(act_issue, exp_issue)), 64'd1);
    chk({tag, "_frag_cnt"}, 64'(act_frag.size()), 64'(exp_frag.size()));
    chk({tag, "_frag_seq"}, 64'(same_q(act_frag, exp_frag)), 64'd1);
  endtask

  initial begin
    int  rx[3], ry[3], bx, by, t, d0;
    bit  got;
    reset = 1'b1;
    tri_valid = 1'b0;
    v0_x = '0; v0_y = '0; v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_tri_ready", 64'(tri_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_valid", 64'(eu_in_valid), 64'd0);
    chk("rst_frag_valid", 64'(frag_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    mode = 0;
    run_tri("t1", 2, 2, 6, 2, 2, 6);
    chk("t1_first_issue_lat", 64'(first_iss_cyc - hs_cyc), 64'd2);
    chk("t1_sustained_rate", 64'(last_iss_cyc - first_iss_cyc), 64'd24);

    run_tri("t2", -5, -5, 3, -5, -5, 3);
    chk("t2_first", (act_issue.size() > 0) ? 64'(act_issue[0]) : 64'hFFFF_FFFF, 64'({11'd0, 11'd0}));
    chk("t2_last", (act_issue.size() > 0) ? 64'(act_issue[act_issue.size()-1]) : 64'hFFFF_FFFF,
        64'({11'd3, 11'd3}));

    run_tri("t3", 700, 10, 710, 10, 700, 20);
    chk("t3_done_lat", 64'(done_cyc - hs_cyc), 64'd2);

    mode = 1;
    run_tri("t4", 2, 2, 6, 2, 2, 6);

    mode = 0;
    run_tri("t5", 4, 4, 4, 4, 4, 4);

    for (int n = 0; n < 4; n++) begin
      mode = n % 2;
      bx = ($urandom_range(0, 1) == 1) ? 610 : 0;
      by = ($urandom_range(0, 1) == 1) ? 450 : 0;
      for (int k = 0; k < 3; k++) begin
        rx[k] = bx + int'($urandom_range(0, 35)) - 10;
        ry[k] = by + int'($urandom_range(0, 35)) - 10;
      end
      if ((rx[1] - rx[0]) * (ry[2] - ry[0]) - (ry[1] - ry[0]) * (rx[2] - rx[0]) < 0) begin
        t = rx[1]; rx[1] = rx[2]; rx[2] = t;
        t = ry[1]; ry[1] = ry[2]; ry[2] = t;
      end
      run_tri("rnd", rx[0], ry[0], rx[1], ry[1], rx[2], ry[2]);
    end

    // Reset in the middle of a scan
    mode = 0;
    send_tri(2, 2, 6, 2, 2, 6);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #2;
      if (act_issue.size() >= 5) got = 1'b1;
    end
    chk("t6_scan_reached", 64'(got), 64'd1);
    chk("t6_busy_in_scan", 64'(busy), 64'd1);
    chk("t6_tri_ready_in_scan", 64'(tri_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    #2;
    chk("t6_tri_ready", 64'(tri_ready), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_frag_valid", 64'(frag_valid), 64'd0);
    chk("t6_in_valid", 64'(eu_in_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    run_tri("t6_after", 2, 2, 6, 2, 2, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
